// File: rtl/encrypt_out_packer.sv
// -----------------------------------------------------------------------------
// encrypt_out_packer
//
// Downstream stage of the XOR encryption pipe. Packs the per-cycle encrypted
// byte stream into 32-bit words (first byte in [7:0]) and queues them in a
// small circular FIFO. Words leave on a valid/ready interface. The upstream
// stage cannot be stalled, so a word that finds the FIFO full is dropped and
// a sticky overflow flag is raised.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   din_valid     byte strobe from the XOR stage
//   din[7:0]      encrypted byte
//   flush         pulse: emit the partially filled word (if any)
//   dout_valid    FIFO head word available
//   dout_ready    consumer accepts head word
//   dout[31:0]    head word (0 when FIFO empty)
//   dout_bytes    valid bytes in dout, 1..4 (0 when FIFO empty)
//   fifo_level    occupied FIFO entries, 0..FIFO_DEPTH
//   overflow      sticky: a word was dropped
//   overflow_clr  clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module encrypt_out_packer #(
   parameter int FIFO_DEPTH = 4            // power of two, >= 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          din_valid,
   input  logic [7:0]                    din,
   input  logic                          flush,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic [31:0]                   dout,
   output logic [2:0]                    dout_bytes,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          overflow_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   // Packer state
   logic [31:0]   acc;
   logic [1:0]    bcnt;

   // Packer combinational view: accumulator and count after this cycle's byte
   logic [31:0]   acc_ins;
   logic [2:0]    cnt_after;
   logic          push_req;

   // FIFO state
   logic [31:0]   mem_data  [FIFO_DEPTH];
   logic [2:0]    mem_bytes [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      acc_ins = acc;
      if (din_valid) begin
         acc_ins[{bcnt, 3'b000} +: 8] = din;
      end
      cnt_after = {1'b0, bcnt} + {2'b00, din_valid};
      // A completed word pushes by itself; flush only adds a push when bytes
      // are pending, so a byte that completes a word with flush gives one push.
      push_req  = cnt_after[2] || (flush && (cnt_after != 3'd0));
   end

   assign full       = (fifo_level == LW'(FIFO_DEPTH));
   assign dout_valid = (fifo_level != '0);
   assign pop        = dout_valid && dout_ready;
   // A full FIFO still takes the word if the head leaves in the same cycle.
   assign push_ok    = push_req && (!full || pop);
   assign drop       = push_req && !push_ok;

   assign dout       = dout_valid ? mem_data[rd_ptr]  : 32'd0;
   assign dout_bytes = dout_valid ? mem_bytes[rd_ptr] : 3'd0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= 32'd0;
         bcnt <= 2'd0;
      end else if (push_req) begin
         // Cleared even when the word is dropped.
         acc  <= 32'd0;
         bcnt <= 2'd0;
      end else begin
         acc  <= acc_ins;
         bcnt <= cnt_after[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   // NOTE: the storage array has no reset; entries are only visible through
   // the level/pointer logic, which is reset, and outputs are masked to zero
   // while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_data[wr_ptr]  <= acc_ins;
         mem_bytes[wr_ptr] <= cnt_after;
      end
   end

endmodule

// File: tb/tb_encrypt_out_packer.sv
// -----------------------------------------------------------------------------
// tb_encrypt_out_packer
//
// Self-checking bench for encrypt_out_packer (FIFO_DEPTH = 4). A table of
// byte/flush vectors with hand-computed words covers the packing rules; short
// hand-written sequences cover overflow, full-with-pop, and reset mid-burst.
// Expected words go into a scoreboard queue when the stimulus is driven and are
// compared by a monitor whenever the DUT hands a word over.
// -----------------------------------------------------------------------------
module tb_encrypt_out_packer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        din_valid;
   logic [7:0]  din;
   logic        flush;
   logic        dout_valid;
   logic        dout_ready;
   logic [31:0] dout;
   logic [2:0]  dout_bytes;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        overflow_clr;

   encrypt_out_packer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .din_valid    (din_valid),
      .din          (din),
      .flush        (flush),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout         (dout),
      .dout_bytes   (dout_bytes),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard entries are {dout_bytes, dout}
   logic [34:0] sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: inputs change #1 after the rising edge, so the falling edge sees
   // the handshake that the next rising edge will act on.
   // ---------------------------------------------------------------------------
   logic        hold_pend = 1'b0;
   logic [34:0] hold_val  = '0;

   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_stable", {dout_bytes, dout}, hold_val);
         end
         hold_pend = dout_valid && !dout_ready;
         hold_val  = {dout_bytes, dout};
         if (dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", {dout_bytes, dout}, 64'hDEAD_0000_0000);
            end else begin
               check("sb_word", {dout_bytes, dout}, sb.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic step(input logic v, input logic [7:0] d, input logic f, input logic clr);
      din_valid    = v;
      din          = d;
      flush        = f;
      overflow_clr = clr;
      @(posedge clk);
      #1;
      din_valid    = 1'b0;
      din          = 8'h00;
      flush        = 1'b0;
      overflow_clr = 1'b0;
   endtask

   // Four consecutive bytes base..base+3, expected word enqueued as driven
   task automatic send_word(input logic [7:0] base);
      logic [7:0] b0, b1, b2, b3;
      b0 = base;
      b1 = base + 8'd1;
      b2 = base + 8'd2;
      b3 = base + 8'd3;
      step(1'b1, b0, 1'b0, 1'b0);
      step(1'b1, b1, 1'b0, 1'b0);
      step(1'b1, b2, 1'b0, 1'b0);
      sb.push_back({3'd4, b3, b2, b1, b0});
      step(1'b1, b3, 1'b0, 1'b0);
   endtask

   task automatic drain();
      dout_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
      end
      check("drain_done", 64'(sb.size()), 64'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_level", fifo_level, 3'd0);
      check("drain_valid", dout_valid, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        f;
      logic        push;
      logic [31:0] word;
      logic [2:0]  nb;
   } vec_t;

   vec_t tbl [18];

   initial begin
      tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 32'h4433_2211,  3'd4};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[6]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_B2A1,  3'd2};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          3'd0};
      tbl[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[11] = '{1'b1, 8'hC3, 1'b1, 1'b1, 32'h00C3_0201,  3'd3};
      tbl[12] = '{1'b1, 8'h05, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[13] = '{1'b1, 8'h06, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[14] = '{1'b1, 8'h07, 1'b0, 1'b0, 32'h0,          3'd0};
      tbl[15] = '{1'b1, 8'h04, 1'b1, 1'b1, 32'h0407_0605,  3'd4};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,          3'd0};
      tbl[17] = '{1'b1, 8'hAA, 1'b1, 1'b1, 32'h0000_00AA,  3'd1};

      // ---- reset state ----
      rst          = 1'b1;
      din_valid    = 1'b0;
      din          = 8'h00;
      flush        = 1'b0;
      dout_ready   = 1'b0;
      overflow_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid",    dout_valid, 1'b0);
      check("rst_dout",     dout,       32'd0);
      check("rst_bytes",    dout_bytes, 3'd0);
      check("rst_level",    fifo_level, 3'd0);
      check("rst_overflow", overflow,   1'b0);
      rst = 1'b0;

      // ---- packing rules, consumer always ready ----
      // With dout_ready=1 a pushed word is visible the cycle after its edge and
      // leaves on the next edge, so valid/level equal this vector's push flag.
      dout_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (tbl[i].push) begin
            sb.push_back({tbl[i].nb, tbl[i].word});
         end
         step(tbl[i].v, tbl[i].d, tbl[i].f, 1'b0);
         check($sformatf("vec%0d_valid", i), dout_valid, tbl[i].push);
         check($sformatf("vec%0d_level", i), fifo_level, {2'b00, tbl[i].push});
         if (tbl[i].push) begin
            check($sformatf("vec%0d_word", i), {dout_bytes, dout}, {tbl[i].nb, tbl[i].word});
         end
      end
      drain();

      // ---- overflow: fill, drop, sticky, clear ----
      dout_ready = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
         send_word(8'h20 + 8'(4 * w));
      end
      check("full_level", fifo_level, 3'd4);
      check("full_no_ovf", overflow, 1'b0);
      step(1'b1, 8'h40, 1'b0, 1'b0);
      step(1'b1, 8'h41, 1'b0, 1'b0);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      check("pre_drop_ovf", overflow, 1'b0);
      step(1'b1, 8'h43, 1'b0, 1'b0);            // completes a word: dropped
      check("drop_ovf",   overflow,   1'b1);
      check("drop_level", fifo_level, 3'd4);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("ovf_sticky", overflow, 1'b1);
      drain();
      check("ovf_after_drain", overflow, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", overflow, 1'b0);

      // clear coincident with a new drop: set wins
      dout_ready = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
         send_word(8'h50 + 8'(4 * w));
      end
      step(1'b1, 8'h60, 1'b0, 1'b0);
      step(1'b1, 8'h61, 1'b0, 1'b0);
      step(1'b1, 8'h62, 1'b0, 1'b0);
      step(1'b1, 8'h63, 1'b0, 1'b1);
      check("clr_vs_drop", overflow, 1'b1);
      check("clr_vs_drop_level", fifo_level, 3'd4);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr2", overflow, 1'b0);
      drain();

      // ---- full FIFO with a pop on the completing cycle ----
      dout_ready = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
         send_word(8'h80 + 8'(4 * w));
      end
      step(1'b1, 8'h90, 1'b0, 1'b0);
      step(1'b1, 8'h91, 1'b0, 1'b0);
      step(1'b1, 8'h92, 1'b0, 1'b0);
      sb.push_back({3'd4, 32'h9392_9190});
      dout_ready = 1'b1;
      step(1'b1, 8'h93, 1'b0, 1'b0);
      check("fullpop_level", fifo_level, 3'd4);
      check("fullpop_ovf",   overflow,   1'b0);
      drain();

      // ---- reset mid-burst ----
      dout_ready = 1'b0;
      send_word(8'hC0);
      send_word(8'hC4);
      step(1'b1, 8'hD0, 1'b0, 1'b0);
      step(1'b1, 8'hD1, 1'b0, 1'b0);
      step(1'b1, 8'hD2, 1'b0, 1'b0);
      check("pre_rst_level", fifo_level, 3'd2);
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      sb.delete();
      check("mid_rst_valid", dout_valid, 1'b0);
      check("mid_rst_dout",  dout,       32'd0);
      check("mid_rst_bytes", dout_bytes, 3'd0);
      check("mid_rst_level", fifo_level, 3'd0);
      check("mid_rst_ovf",   overflow,   1'b0);
      rst        = 1'b0;
      dout_ready = 1'b1;
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b1, 8'h6B, 1'b0, 1'b0);
      step(1'b1, 8'h7C, 1'b0, 1'b0);
      sb.push_back({3'd4, 32'h8D7C_6B5A});
      step(1'b1, 8'h8D, 1'b0, 1'b0);
      check("fresh_word", {dout_bytes, dout}, {3'd4, 32'h8D7C_6B5A});
      drain();

      check("sb_final_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/encrypt_out_packer.md
# encrypt_out_packer

Downstream stage of the XOR encryption pipe: consumes the per-cycle encrypted byte stream (`encrypted_data`/`encrypted_valid`), packs bytes into 32-bit words and buffers them in a small FIFO. Words leave on a valid/ready interface towards the bus/output interface. The XOR stage has no backpressure, so this block absorbs bursts and reports loss through a sticky overflow flag.

## Interface
- `FIFO_DEPTH`, default 4: number of 32-bit word entries; power of two, ≥2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `din_valid` input 1: byte strobe (driven by XOR stage `encrypted_valid`).
- `din` input 8: encrypted byte (driven by XOR stage `encrypted_data`).
- `flush` input 1: single-cycle pulse; emit partially filled word.
- `dout_valid` output 1: FIFO head word available.
- `dout_ready` input 1: consumer accepts head word.
- `dout` output 32: packed word; first byte received in `[7:0]`, fourth in `[31:24]`.
- `dout_bytes` output 3: number of valid bytes in `dout`, 1..4.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: occupied FIFO entries.
- `overflow` output 1: sticky; a word was dropped.
- `overflow_clr` input 1: clears `overflow`.

## Operation
- Packer state: accumulator `acc[31:0]`, byte counter `bcnt` 0..3.
- `din_valid`=1: byte written to `acc[8*bcnt +: 8]`; if `bcnt`=3, word pushed with `dout_bytes`=4, `acc` cleared, `bcnt`←0; else `bcnt`←`bcnt`+1.
- `flush`=1 with `bcnt`>0 (after accounting for a same-cycle byte): push `acc` (unused upper bytes zero) with `dout_bytes`=byte count; `acc` cleared, `bcnt`←0.
- `flush` with no pending bytes and no same-cycle byte: no-op, nothing pushed.
- `flush` and `din_valid` same cycle: byte included first, then flushed; exactly one push per cycle (if the byte completes a word, one push with count 4, no extra empty word).
- FIFO: circular buffer, read/write pointers wrap modulo `FIFO_DEPTH`; `fifo_level` tracks occupancy 0..`FIFO_DEPTH`.
- Pop when `dout_valid && dout_ready`.
- Push when full: accepted only if a pop occurs in the same cycle (level unchanged); otherwise word dropped, `overflow`←1, `acc`/`bcnt` still cleared.
- Push and pop same cycle when empty: not possible (no show-through); push lands, level 0→1.
- `overflow_clr` clears `overflow`; if a drop occurs in the same cycle, set wins.
- `dout`/`dout_bytes` reflect FIFO head; both forced to 0 when FIFO empty.

## Timing
- Reset (rst=1 at edge): `dout_valid`=0, `dout`=0, `dout_bytes`=0, `fifo_level`=0, `overflow`=0, `acc`=0, `bcnt`=0; pending bytes and FIFO contents discarded. Reset mid-burst: partial word lost, no flag.
- Latency: word-completing byte (or flush) sampled at edge N → `dout_valid`=1 in cycle after edge N when FIFO was empty.
- Throughput: one byte/cycle in sustained; max one word/cycle out.
- `dout`, `dout_bytes` held stable while `dout_valid && !dout_ready`.
- `fifo_level`, `overflow` registered; update on the edge of the causing event.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44 on four consecutive cycles, `dout_ready`=1 → one word 0x44332211, `dout_bytes`=4, `dout_valid` high one cycle after 0x44 sampled.
- Bytes 0xA1,0xB2 then `flush` pulse → word 0x0000B2A1, `dout_bytes`=2; second `flush` with nothing pending → no word.
- Byte 0xC3 with `flush` in same cycle after two pending bytes 0x01,0x02 → single word 0x00C30201, `dout_bytes`=3; byte 0x04 completing word plus `flush` → single word, count 4.
- `dout_ready`=0, stream 4*`FIFO_DEPTH` bytes (FIFO full, level=4), 4 more bytes → fifth word dropped, `overflow`=1, level stays 4; drain in order; `overflow_clr` → 0; clr coincident with new drop → stays 1.
- FIFO full with `dout_ready`=1 on the cycle a new word completes → push accepted, no overflow, level stays 4, data order preserved across pointer wrap.
- Assert `rst` after 3 bytes pending and 2 words queued → all outputs 0 next cycle; subsequent 4 bytes form a fresh word with no stale data.
